// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 command responder: command encodings,
// protocol-error bit positions, geometry and default timing values.
package ddr3_pkg;

    // {ras_n, cas_n, we_n} when cs_n=0 and cke=1
    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_REF   = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_ZQ    = 3'b110,
        CMD_NOP   = 3'b111
    } ddr3_cmd_t;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_t;

    // err_flags bit positions
    localparam int ERR_ACT_OPEN = 0;  // ACT to an already open bank
    localparam int ERR_ACT_TRP  = 1;  // ACT before tRP elapsed
    localparam int ERR_RD_IDLE  = 2;  // READ to a closed bank
    localparam int ERR_RD_TRCD  = 3;  // READ before tRCD elapsed
    localparam int ERR_PRE_TRAS = 4;  // PRE before tRAS elapsed
    localparam int ERR_REF_OPEN = 5;  // REF with any bank open
    localparam int ERR_W        = 6;

    localparam int NUM_BANKS = 8;
    localparam int BA_W      = 3;
    localparam int ROW_W     = 14;
    localparam int COL_W     = 10;
    localparam int TMR_W     = 5;
    localparam int WORD_W    = 32;
    localparam int LINE_W    = 512;
    localparam int CNT_W     = 32;

    localparam int DEF_CL   = 6;
    localparam int DEF_TRCD = 5;
    localparam int DEF_TRP  = 5;
    localparam int DEF_TRAS = 15;

    // Timing counters count down to zero and then stay there
    function automatic logic [TMR_W-1:0] tmr_dec(input logic [TMR_W-1:0] v);
        return (v == '0) ? v : v - TMR_W'(1);
    endfunction

    // One 32-bit read word: {5'b0, bank, open row, column}
    function automatic logic [WORD_W-1:0] rd_word(input logic [BA_W-1:0]  b,
                                                  input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
        return {5'b0, b, row, col};
    endfunction

endpackage

// File: rtl/ddr3_bank_fsm.sv
// Per-bank tracker: IDLE/ACTIVE state, open row, and the tRCD/tRAS/tRP
// down-counters. Flags protocol violations seen by commands aimed at this
// bank; commands always observe the counter value from before this edge.
module ddr3_bank_fsm
    import ddr3_pkg::*;
#(
    parameter int TRCD = DEF_TRCD,
    parameter int TRP  = DEF_TRP,
    parameter int TRAS = DEF_TRAS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             act_cmd,
    input  logic             pre_cmd,
    input  logic             rd_cmd,
    input  logic [ROW_W-1:0] row_in,
    output logic             bank_open,
    output logic [ROW_W-1:0] open_row,
    output logic             rd_accept,
    output logic             err_act_open,
    output logic             err_act_trp,
    output logic             err_rd_idle,
    output logic             err_rd_trcd,
    output logic             err_pre_tras
);

    localparam logic [TMR_W-1:0] TRCD_LD = TMR_W'(TRCD - 1);
    localparam logic [TMR_W-1:0] TRP_LD  = TMR_W'(TRP - 1);
    localparam logic [TMR_W-1:0] TRAS_LD = TMR_W'(TRAS - 1);

    bank_state_t      state, state_nxt;
    logic [ROW_W-1:0] row_nxt;
    logic [TMR_W-1:0] trcd_cnt, tras_cnt, trp_cnt;
    logic [TMR_W-1:0] trcd_nxt, tras_nxt, trp_nxt;

    // State, open row and timing counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BANK_IDLE;
            open_row <= '0;
            trcd_cnt <= '0;
            tras_cnt <= '0;
            trp_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            open_row <= row_nxt;
            trcd_cnt <= trcd_nxt;
            tras_cnt <= tras_nxt;
            trp_cnt  <= trp_nxt;
        end
    end

    // Next state, counter reloads and violation checks for this bank
    always_comb begin
        state_nxt    = state;
        row_nxt      = open_row;
        trcd_nxt     = tmr_dec(trcd_cnt);
        tras_nxt     = tmr_dec(tras_cnt);
        trp_nxt      = tmr_dec(trp_cnt);
        rd_accept    = 1'b0;
        err_act_open = 1'b0;
        err_act_trp  = 1'b0;
        err_rd_idle  = 1'b0;
        err_rd_trcd  = 1'b0;
        err_pre_tras = 1'b0;
        case (state)
            BANK_IDLE: begin
                if (act_cmd) begin
                    state_nxt   = BANK_ACTIVE;
                    row_nxt     = row_in;
                    trcd_nxt    = TRCD_LD;
                    tras_nxt    = TRAS_LD;
                    err_act_trp = (trp_cnt != '0);
                end
                if (rd_cmd) begin
                    err_rd_idle = 1'b1;
                end
            end
            BANK_ACTIVE: begin
                if (act_cmd) begin
                    err_act_open = 1'b1;
                end
                if (rd_cmd) begin
                    rd_accept   = 1'b1;
                    err_rd_trcd = (trcd_cnt != '0);
                end
                if (pre_cmd) begin
                    state_nxt    = BANK_IDLE;
                    trp_nxt      = TRP_LD;
                    err_pre_tras = (tras_cnt != '0);
                end
            end
            default: state_nxt = BANK_IDLE;
        endcase
    end

    assign bank_open = (state == BANK_ACTIVE);

endmodule

// File: rtl/ddr3_cmd_responder.sv
// DDR3 command-bus responder: decodes commands, tracks eight banks, returns
// a synthetic read line CL cycles after each accepted READ, and keeps sticky
// protocol-violation flags plus wrapping ACT/READ/PRE counts.
module ddr3_cmd_responder
    import ddr3_pkg::*;
#(
    parameter int CL   = DEF_CL,
    parameter int TRCD = DEF_TRCD,
    parameter int TRP  = DEF_TRP,
    parameter int TRAS = DEF_TRAS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cke,
    input  logic              cs_n,
    input  logic              ras_n,
    input  logic              cas_n,
    input  logic              we_n,
    input  logic [BA_W-1:0]   ba,
    input  logic [ROW_W-1:0]  addr,
    input  logic              odt,
    output logic              rd_valid,
    output logic [LINE_W-1:0] rd_data,
    output logic [ERR_W-1:0]  err_flags,
    output logic [CNT_W-1:0]  act_seen,
    output logic [CNT_W-1:0]  rd_seen,
    output logic [CNT_W-1:0]  pre_seen
);

    ddr3_cmd_t cmd;
    logic      cmd_vld;
    logic      is_act, is_rd, is_pre, is_ref;

    logic [NUM_BANKS-1:0] act_cmd, pre_cmd, rd_cmd;
    logic [NUM_BANKS-1:0] bank_open, rd_accept;
    logic [NUM_BANKS-1:0] e_act_open, e_act_trp, e_rd_idle, e_rd_trcd, e_pre_tras;
    logic [ROW_W-1:0]     open_row [NUM_BANKS];

    logic                 rd_go_p0;
    logic [WORD_W-1:0]    word_p0;
    logic [CL-1:0]        vld_pn;
    logic [WORD_W-1:0]    word_pn [CL];
    logic [ERR_W-1:0]     err_set;

    // odt is accepted on the interface but has no function here
    logic unused_odt;
    assign unused_odt = odt;

    // Command decode; a deselected or clock-disabled cycle decodes as nothing
    always_comb begin
        cmd_vld = cke & ~cs_n;
        cmd     = ddr3_cmd_t'({ras_n, cas_n, we_n});
        is_act  = cmd_vld && (cmd == CMD_ACT);
        is_rd   = cmd_vld && (cmd == CMD_READ);
        is_pre  = cmd_vld && (cmd == CMD_PRE);
        is_ref  = cmd_vld && (cmd == CMD_REF);
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign act_cmd[b] = is_act && (ba == BA_W'(b));
        assign rd_cmd[b]  = is_rd  && (ba == BA_W'(b));
        assign pre_cmd[b] = is_pre && (addr[10] || (ba == BA_W'(b)));

        ddr3_bank_fsm #(
            .TRCD (TRCD),
            .TRP  (TRP),
            .TRAS (TRAS)
        ) u_bank (
            .clk          (clk),
            .rst_n        (rst_n),
            .act_cmd      (act_cmd[b]),
            .pre_cmd      (pre_cmd[b]),
            .rd_cmd       (rd_cmd[b]),
            .row_in       (addr),
            .bank_open    (bank_open[b]),
            .open_row     (open_row[b]),
            .rd_accept    (rd_accept[b]),
            .err_act_open (e_act_open[b]),
            .err_act_trp  (e_act_trp[b]),
            .err_rd_idle  (e_rd_idle[b]),
            .err_rd_trcd  (e_rd_trcd[b]),
            .err_pre_tras (e_pre_tras[b])
        );
    end

    // ---- stage p0: READ accepted at the command edge, word formed from the open row
    assign rd_go_p0 = |rd_accept;
    assign word_p0  = rd_word(ba, open_row[ba], addr[COL_W-1:0]);

    // Read-valid shift chain; one slot per cycle of latency, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pn <= '0;
        end else begin
            vld_pn[0] <= rd_go_p0;
            for (int k = 1; k < CL; k++) begin
                vld_pn[k] <= vld_pn[k-1];
            end
        end
    end

    // Read-word shift chain travelling with vld_pn; its valid bit qualifies it
    always_ff @(posedge clk) begin
        word_pn[0] <= word_p0;
        for (int k = 1; k < CL; k++) begin
            word_pn[k] <= word_pn[k-1];
        end
    end

    // ---- output stage: line presented CL edges after the READ, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= vld_pn[CL-1];
            if (vld_pn[CL-1]) begin
                rd_data <= {(LINE_W/WORD_W){word_pn[CL-1]}};
            end
        end
    end

    // Collect this cycle's violations from all banks plus the REF check
    always_comb begin
        err_set               = '0;
        err_set[ERR_ACT_OPEN] = |e_act_open;
        err_set[ERR_ACT_TRP]  = |e_act_trp;
        err_set[ERR_RD_IDLE]  = |e_rd_idle;
        err_set[ERR_RD_TRCD]  = |e_rd_trcd;
        err_set[ERR_PRE_TRAS] = |e_pre_tras;
        err_set[ERR_REF_OPEN] = is_ref && (|bank_open);
    end

    // Sticky error flags; only reset clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flags <= '0;
        end else begin
            err_flags <= err_flags | err_set;
        end
    end

    // Wrapping command counts; a PRE-all is one command and counts once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_seen <= '0;
            rd_seen  <= '0;
            pre_seen <= '0;
        end else begin
            if (is_act) act_seen <= act_seen + CNT_W'(1);
            if (is_rd)  rd_seen  <= rd_seen  + CNT_W'(1);
            if (is_pre) pre_seen <= pre_seen + CNT_W'(1);
        end
    end

endmodule
